gray_counter: RTL and testbench
===============================

// Module: gray_counter
// PURPOSE
//   Parametrised up/down counter that holds its count in binary and in Gray code.
//   Both forms come from registers and are updated in the same cycle.
//   Gray-coded loads are accepted, and the counter can wrap or saturate.
//   Used as a pointer/position source wherever a one-bit-change code crosses
//   into other logic. The conversions match the bin2gray/gray2bin definitions.
// PARAMETERS
//   LENGTH      8  counter width in bits (>= 2)
//   SATURATE    0  0: wrap modulo 2**LENGTH; 1: hold at all-ones (up) or zero (down)
//   RESET_VALUE 0  binary count loaded by reset (LENGTH bits)
// PORTS
//   clk            in   1       clock, rising edge
//   rst            in   1       synchronous reset, active-high
//   en             in   1       count enable
//   up             in   1       1: increment; 0: decrement (sampled only when counting)
//   load           in   1       load load_gray into counter
//   load_gray      in   LENGTH  load value, Gray-coded
//   binary_output  out  LENGTH  registered count, binary
//   gray_output    out  LENGTH  registered count, Gray: b ^ (b >> 1)
//   wrap           out  1       registered 1-cycle pulse: count wrapped this step
//   at_max         out  1       registered: binary_output == all-ones
//   at_min         out  1       registered: binary_output == 0
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high. All outputs are registered.
//   - Priority each rising edge: rst > load > en > hold.
//   - Reset values:
//     - binary_output = RESET_VALUE; gray_output = Gray(RESET_VALUE); wrap = 0.
//     - at_max = (RESET_VALUE == all-ones); at_min = (RESET_VALUE == 0).
//   - Load (load=1, regardless of en/up):
//     - next binary = gray2bin(load_gray); next gray = load_gray, unchanged.
//     - wrap = 0. Latency 1 cycle.
//   - Count (en=1, load=0):
//     - up=1: next = binary+1; up=0: next = binary-1 (LENGTH-bit arithmetic).
//     - Wrap mode, up at all-ones: next = 0, wrap = 1 for one cycle.
//     - Wrap mode, down at 0: next = all-ones, wrap = 1 for one cycle.
//     - Saturate mode at a limit in the count direction: count holds, wrap stays 0.
//   - Hold (en=0, load=0): count unchanged, wrap = 0.
//   - wrap, at_max and at_min describe the value shown on binary_output in the same cycle.
//   - Gray output comes from the next binary value in the same clock edge.
//     - No extra latency.
//     - Never derived combinationally from the registered binary value.
//   - Invariant: a single count step, including a wrap, changes exactly one gray_output bit.
//   - A direction change between steps is legal, with no dead cycle.
//   - Reset asserted mid-count overrides load/en that cycle; counting resumes the cycle
//     after rst drops.
//   - No X propagation: load_gray is only sampled when load=1.
// TESTING
//   1. Reset, LENGTH=4, RESET_VALUE=0:
//      -> binary 0, gray 0000, at_min=1, at_max=0, wrap=0.
//   2. en=1, up=1, 16 cycles from 0 (wrap mode):
//      -> binary 1..15,0; gray 0001,0011,...,1000,0000.
//      -> wrap=1 only on the cycle showing 0; every step changes exactly 1 gray bit.
//   3. load=1, load_gray=4'b1100, en=1 in the same cycle:
//      -> next cycle binary=8, gray=1100, wrap=0 (load wins over en).
//   4. SATURATE=1, counting up from 14 for 4 cycles:
//      -> binary 15,15,15,15; at_max=1 from the first 15; wrap never asserts.
//   5. Down from 1 (wrap mode):
//      -> 0 (at_min=1), then 15 with wrap=1, then 14.
//      -> Flip up=1 at 14: next 15, no idle cycle.
//   6. rst=1 together with load=1 and en=1 while mid-count at 9:
//      -> next cycle RESET_VALUE with reset flags; counting resumes the cycle after rst=0.

Source files
------------

// File: rtl/gray_counter.sv
// Up/down counter holding its count as registered binary and registered Gray.
// Gray-coded loads are supported; the count either wraps or saturates at the limits.
module gray_counter #(
  parameter int                LENGTH      = 8,
  parameter int                SATURATE    = 0,
  parameter logic [LENGTH-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up,
  input  logic              load,
  input  logic [LENGTH-1:0] load_gray,
  output logic [LENGTH-1:0] binary_output,
  output logic [LENGTH-1:0] gray_output,
  output logic              wrap,
  output logic              at_max,
  output logic              at_min
);

  localparam logic [LENGTH-1:0] ALL_ONES   = '1;
  localparam logic [LENGTH-1:0] ONE        = LENGTH'(1);
  localparam logic [LENGTH-1:0] RESET_GRAY = RESET_VALUE ^ (RESET_VALUE >> 1);

  function automatic logic [LENGTH-1:0] bin2gray(input logic [LENGTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of the Gray bits at and above it.
  function automatic logic [LENGTH-1:0] gray2bin(input logic [LENGTH-1:0] g);
    logic [LENGTH-1:0] b;
    b[LENGTH-1] = g[LENGTH-1];
    for (int i = LENGTH-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [LENGTH-1:0] bin_nxt, gray_nxt;
  logic              wrap_nxt;

  always_comb begin
    bin_nxt  = binary_output;
    gray_nxt = gray_output;
    wrap_nxt = 1'b0;
    if (load) begin
      bin_nxt  = gray2bin(load_gray);
      gray_nxt = load_gray;
    end else if (en) begin
      if (up) begin
        if (binary_output != ALL_ONES) begin
          bin_nxt = binary_output + ONE;
        end else if (SATURATE == 0) begin
          bin_nxt  = '0;
          wrap_nxt = 1'b1;
        end
      end else begin
        if (binary_output != '0) begin
          bin_nxt = binary_output - ONE;
        end else if (SATURATE == 0) begin
          bin_nxt  = ALL_ONES;
          wrap_nxt = 1'b1;
        end
      end
      // Gray is registered from the next binary value, never from the current output.
      gray_nxt = bin2gray(bin_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      binary_output <= RESET_VALUE;
      gray_output   <= RESET_GRAY;
      wrap          <= 1'b0;
      at_max        <= (RESET_VALUE == ALL_ONES);
      at_min        <= (RESET_VALUE == '0);
    end else begin
      binary_output <= bin_nxt;
      gray_output   <= gray_nxt;
      wrap          <= wrap_nxt;
      at_max        <= (bin_nxt == ALL_ONES);
      at_min        <= (bin_nxt == '0);
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter: wrap, saturate and nonzero-reset instances
// share one stimulus stream; each is checked as {binary, gray, wrap, at_max, at_min}.
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [3:0] load_gray;

  logic [3:0] bw, gw, bs, gs, br, gr;
  logic       ww, xw, nw, ws, xs, ns, wr, xr, nr;
  logic [10:0] ow, os, orr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_counter #(.LENGTH(4), .SATURATE(0), .RESET_VALUE(4'h0)) dut_w (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
    .binary_output(bw), .gray_output(gw), .wrap(ww), .at_max(xw), .at_min(nw));

  gray_counter #(.LENGTH(4), .SATURATE(1), .RESET_VALUE(4'h0)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
    .binary_output(bs), .gray_output(gs), .wrap(ws), .at_max(xs), .at_min(ns));

  gray_counter #(.LENGTH(4), .SATURATE(0), .RESET_VALUE(4'hF)) dut_r (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
    .binary_output(br), .gray_output(gr), .wrap(wr), .at_max(xr), .at_min(nr));

  assign ow  = {bw, gw, ww, xw, nw};
  assign os  = {bs, gs, ws, xs, ns};
  assign orr = {br, gr, wr, xr, nr};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_gray = 4'b0000;
    step(); step();
    checks++; if (ow !== {4'd0, 4'b0000, 3'b001}) begin errors++;
      $display("FAIL reset_wrap: got %b expected %b", ow, {4'd0, 4'b0000, 3'b001}); end
    checks++; if (os !== {4'd0, 4'b0000, 3'b001}) begin errors++;
      $display("FAIL reset_sat: got %b expected %b", os, {4'd0, 4'b0000, 3'b001}); end
    checks++; if (orr !== {4'd15, 4'b1000, 3'b010}) begin errors++;
      $display("FAIL reset_value15: got %b expected %b", orr, {4'd15, 4'b1000, 3'b010}); end
  endtask

  task automatic test_count_up;
    logic [3:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                              4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                              4'b1010, 4'b1011, 4'b1001, 4'b1000};
    logic [3:0] prev;
    logic [3:0] eb;
    logic [10:0] exp_w;
    rst = 1'b0; en = 1'b1; up = 1'b1;
    prev = gw;
    for (int i = 0; i < 16; i++) begin
      step();
      eb = 4'(i + 1);
      exp_w = {eb, gtab[eb], (eb == 4'd0), (eb == 4'd15), (eb == 4'd0)};
      checks++; if (ow !== exp_w) begin errors++;
        $display("FAIL count_up[%0d]: got %b expected %b", i, ow, exp_w); end
      checks++; if ($countones(gw ^ prev) !== 1) begin errors++;
        $display("FAIL gray_one_bit[%0d]: got %b after %b, expected one bit change", i, gw, prev); end
      prev = gw;
    end
    checks++; if (os !== {4'd15, 4'b1000, 3'b010}) begin errors++;
      $display("FAIL count_up_sat_hold: got %b expected %b", os, {4'd15, 4'b1000, 3'b010}); end
  endtask

  task automatic test_load;
    load = 1'b1; load_gray = 4'b1100; en = 1'b1; up = 1'b1;
    step();
    load = 1'b0; load_gray = 4'bxxxx;
    checks++; if (ow !== {4'd8, 4'b1100, 3'b000}) begin errors++;
      $display("FAIL load_over_en: got %b expected %b", ow, {4'd8, 4'b1100, 3'b000}); end
    checks++; if (os !== {4'd8, 4'b1100, 3'b000}) begin errors++;
      $display("FAIL load_sat: got %b expected %b", os, {4'd8, 4'b1100, 3'b000}); end
  endtask

  task automatic test_hold;
    en = 1'b0; up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (ow !== {4'd8, 4'b1100, 3'b000}) begin errors++;
        $display("FAIL hold[%0d]: got %b expected %b", i, ow, {4'd8, 4'b1100, 3'b000}); end
    end
  endtask

  task automatic test_saturate;
    logic [10:0] exp_w [4] = '{{4'd15, 4'b1000, 3'b010}, {4'd0, 4'b0000, 3'b101},
                               {4'd1, 4'b0001, 3'b000}, {4'd2, 4'b0011, 3'b000}};
    load = 1'b1; load_gray = 4'b1001; en = 1'b0;
    step();
    checks++; if (os !== {4'd14, 4'b1001, 3'b000}) begin errors++;
      $display("FAIL sat_load14: got %b expected %b", os, {4'd14, 4'b1001, 3'b000}); end
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (os !== {4'd15, 4'b1000, 3'b010}) begin errors++;
        $display("FAIL sat_up[%0d]: got %b expected %b", i, os, {4'd15, 4'b1000, 3'b010}); end
      checks++; if (ow !== exp_w[i]) begin errors++;
        $display("FAIL wrap_up[%0d]: got %b expected %b", i, ow, exp_w[i]); end
    end
  endtask

  task automatic test_down_and_turn;
    logic [10:0] exp_w [4] = '{{4'd0, 4'b0000, 3'b001}, {4'd15, 4'b1000, 3'b110},
                               {4'd14, 4'b1001, 3'b000}, {4'd15, 4'b1000, 3'b010}};
    logic [10:0] exp_s [4] = '{{4'd0, 4'b0000, 3'b001}, {4'd0, 4'b0000, 3'b001},
                               {4'd0, 4'b0000, 3'b001}, {4'd1, 4'b0001, 3'b000}};
    load = 1'b1; load_gray = 4'b0001; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1; up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) up = 1'b1;
      step();
      checks++; if (ow !== exp_w[i]) begin errors++;
        $display("FAIL down_wrap[%0d]: got %b expected %b", i, ow, exp_w[i]); end
      checks++; if (os !== exp_s[i]) begin errors++;
        $display("FAIL down_sat[%0d]: got %b expected %b", i, os, exp_s[i]); end
    end
  endtask

  task automatic test_reset_mid_count;
    load = 1'b1; load_gray = 4'b1101; en = 1'b0;
    step();
    checks++; if (ow !== {4'd9, 4'b1101, 3'b000}) begin errors++;
      $display("FAIL mid_load9: got %b expected %b", ow, {4'd9, 4'b1101, 3'b000}); end
    rst = 1'b1; load = 1'b1; load_gray = 4'b1111; en = 1'b1; up = 1'b1;
    step();
    checks++; if (ow !== {4'd0, 4'b0000, 3'b001}) begin errors++;
      $display("FAIL mid_reset: got %b expected %b", ow, {4'd0, 4'b0000, 3'b001}); end
    checks++; if (orr !== {4'd15, 4'b1000, 3'b010}) begin errors++;
      $display("FAIL mid_reset_value15: got %b expected %b", orr, {4'd15, 4'b1000, 3'b010}); end
    rst = 1'b0; load = 1'b0;
    step();
    checks++; if (ow !== {4'd1, 4'b0001, 3'b000}) begin errors++;
      $display("FAIL resume_after_reset: got %b expected %b", ow, {4'd1, 4'b0001, 3'b000}); end
    checks++; if (orr !== {4'd0, 4'b0000, 3'b101}) begin errors++;
      $display("FAIL resume_value15_wrap: got %b expected %b", orr, {4'd0, 4'b0000, 3'b101}); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_load();
    test_hold();
    test_saturate();
    test_down_and_turn();
    test_reset_mid_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
